// File: rtl/jk_command_driver.sv
// rtl/jk_command_driver.sv - Moore command sequencer driving j/k of a downstream JK flip-flop
// Accepts {op,count} over a dav_/rfd handshake and holds op on j/k for count cycles.
module jk_command_driver #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         dav_,
  output logic         rfd,
  input  logic [1:0]   op,
  input  logic [W-1:0] count,
  output logic         j,
  output logic         k,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACK   = 2'b01,
    S_DRIVE = 2'b10
  } star_t;

  star_t        star, star_nxt;
  logic [1:0]   op_r, op_nxt;
  logic [W-1:0] cnt_r, cnt_nxt;
  logic         rfd_nxt, j_nxt, k_nxt, busy_nxt;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star  <= S_IDLE;
      op_r  <= '0;
      cnt_r <= '0;
      rfd   <= 1'b1;
      j     <= 1'b0;
      k     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      star  <= star_nxt;
      op_r  <= op_nxt;
      cnt_r <= cnt_nxt;
      rfd   <= rfd_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    star_nxt = star;
    op_nxt   = op_r;
    cnt_nxt  = cnt_r;
    rfd_nxt  = rfd;
    j_nxt    = j;
    k_nxt    = k;
    busy_nxt = busy;
    case (star)
      S_IDLE: begin
        if (!dav_) begin
          op_nxt   = op;
          cnt_nxt  = count;
          rfd_nxt  = 1'b0;
          busy_nxt = 1'b1;
          star_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (dav_) begin
          if (cnt_r == '0) begin
            // Zero-count command completes without ever asserting j/k.
            rfd_nxt  = 1'b1;
            busy_nxt = 1'b0;
            star_nxt = S_IDLE;
          end else begin
            {j_nxt, k_nxt} = op_r;
            star_nxt       = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        cnt_nxt = cnt_r - W'(1);
        if (cnt_r == W'(1)) begin
          j_nxt    = 1'b0;
          k_nxt    = 1'b0;
          rfd_nxt  = 1'b1;
          busy_nxt = 1'b0;
          star_nxt = S_IDLE;
        end
      end
      default: begin
        star_nxt = S_IDLE;
        op_nxt   = '0;
        cnt_nxt  = '0;
        rfd_nxt  = 1'b1;
        j_nxt    = 1'b0;
        k_nxt    = 1'b0;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/jk_command_driver.md
Name: jk_command_driver

Overview:
- Moore-model sequential stage that sits directly upstream of the JK flip-flop and generates its j/k inputs.
- Accepts commands from a producer over a dav_/rfd handshake. Each command is a 2-bit opcode plus a repeat count.
- Opcode encoding matches the flip-flop: 00 hold, 10 set, 01 reset, 11 toggle.
- Drives the opcode on j/k for exactly COUNT clock cycles, then returns j/k to 00 (hold) and is ready for the next command.

Parameters:
W  4  width of the repeat-count field; maximum repeat is 2^W-1

Ports:
clock  input  1  system clock, all state changes on posedge
reset_  input  1  asynchronous, active-low reset
dav_  input  1  data-valid from producer, active low
rfd  output  1  ready-for-data to producer, active high
op  input  2  command opcode {j,k}; sampled only when a command is accepted
count  input  W  repeat count; sampled together with op
j  output  1  J input of the downstream flip-flop
k  output  1  K input of the downstream flip-flop
busy  output  1  high in every state except the idle wait state

Behaviour:
- All outputs are registered (Moore); none depends combinationally on inputs.
- Reset (reset_==0), asynchronous, takes effect regardless of clock:
  - STAR=S_IDLE, rfd=1, j=0, k=0, busy=0; internal OP and CNT registers cleared to 0.
  - While reset_ is held low, clock edges have no effect.
- S_IDLE (rfd=1, j=k=0, busy=0):
  - On a posedge with dav_==0: OP<=op, CNT<=count, rfd<=0, busy<=1, go to S_ACK.
  - Otherwise stay in S_IDLE.
- S_ACK (rfd=0, j=k=0, busy=1), waits for the producer to release dav_:
  - On a posedge with dav_==1:
    - if CNT==0: rfd<=1, busy<=0, go to S_IDLE (no-op command, j/k never asserted);
    - else: {j,k}<=OP, go to S_DRIVE.
  - While dav_ stays 0, remain in S_ACK indefinitely.
- S_DRIVE (rfd=0, busy=1, {j,k}=OP):
  - Each posedge does CNT<=CNT-1.
  - On the posedge where CNT==1: {j,k}<=00, rfd<=1, busy<=0, go to S_IDLE.
  - Net effect: j/k hold OP for exactly N = count rising edges of the downstream flip-flop.
- Opcode 00 with nonzero count is legal: the block sits in S_DRIVE for N cycles with j=k=0.
- Latency:
  - dav_ falling, sampled at edge E0: rfd falls after E0.
  - dav_ rising, sampled at edge E1: j/k valid after E1, held through edges E1+1 … E1+N.
  - rfd rises and j/k return to 0 after edge E1+N.
- dav_ activity while busy in S_DRIVE is ignored. op and count are not re-sampled. rfd stays 0, so a compliant producer does not assert dav_.
- A producer that holds dav_==0 across the S_DRIVE → S_IDLE transition is treated as a new command and accepted on the next edge.
- Count arithmetic is unsigned, W bits. count = 2^W-1 (15 by default) gives 15 drive cycles; no wrap occurs because CNT is never decremented from 0.
- Reset asserted mid-S_DRIVE: the command is aborted immediately, j=k=0, and the remaining count is discarded.
- Reset asserted mid-S_ACK: the handshake is abandoned and rfd returns to 1.
- Unused state encodings fall back to S_IDLE on the next posedge with the reset values.

Test Plan:
- Reset: pulse reset_ low for 2 cycles with random inputs → rfd=1, j=0, k=0, busy=0 while low and on the first edge after release.
- Set command: op=10, count=3 with full handshake → j=1, k=0 for exactly 3 posedges after dav_ release, then j=k=0, rfd=1. Downstream flip-flop q goes 0→1.
- Toggle command: op=11, count=5, q initially 0 → j=k=1 for 5 edges. Flip-flop toggles 5 times and ends at q=1. busy=1 throughout, then 0.
- Zero count: op=11, count=0 → j/k never asserted; rfd returns to 1 one edge after dav_ rises; busy high for exactly 2 cycles.
- Slow producer: dav_ held low 6 cycles after rfd falls → block stays in S_ACK with j=k=0. Drive starts only on the edge sampling dav_==1.
- Abort: op=01, count=15, assert reset_ after the 4th drive edge → j=k=0 and rfd=1 asynchronously. A following command op=10, count=1 executes normally with a single drive cycle.
